rram_drive_monitor: RTL and testbench
=====================================

Name: rram_drive_monitor

Overview:
- Receive-side protocol checker for the RRAM unit drive interface: wordlines, sourcelines, bitlines, set, back and label.
- Decodes the phase sequence IDLE → WL on → init (set) → feed-forward → error calc (label) → weight update (back) → post.
- Flags illegal transitions and dwell violations, counts weight-update bitline pulses and captures feed-forward row select.
- Sits in parallel with the RRAM unit, on the same nets the drive sequencer/testbench writes; passive, no outputs back onto the array.

Parameters:
- N, 12, number of wordlines/sourcelines/bitlines.
- MIN_DWELL, 1, minimum sampled cycles each phase (except IDLE and FAULT) must be held before leaving it.
- CNT_W, 8, width of update-pulse counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wl  in  N  wordline drive, bit i = Dwl<i>.
- sl  in  N  sourceline drive.
- bl  in  N  bitline drive.
- set  in  1  set/initialise strobe.
- back  in  1  backprop/weight-update strobe.
- label  in  1  label/error-calc strobe.
- clear  in  1  synchronous clear of err, err_code, counters and captures; state forced to S_IDLE.
- phase  out  3  current FSM state encoding.
- err  out  1  sticky protocol error.
- err_code  out  2  first error cause.
- ff_rows  out  N  sl value captured on entry to S_FEED.
- upd_cnt  out  CNT_W  number of update pulses in current sequence.
- seq_done  out  1  one-cycle pulse on S_UPD→S_POST.

Behaviour:
- Input stage: all inputs except clear/rst registered once. FSM acts on the registered copy, so phase reflects the drive pins 2 rising edges after a change.
- Clock/reset: one clock, synchronous active-high rst.
- Reset / clear values: phase = S_IDLE, err = 0, err_code = 0, ff_rows = 0, upd_cnt = 0, seq_done = 0, input register = 0, dwell counter = 0, prev_bl = 0.
- Phase encodings: S_IDLE=0, S_WLON=1, S_INIT=2, S_FEED=3, S_ERR=4, S_UPD=5, S_POST=6, S_FAULT=7.
- Decoded input classes, with ALL = all-ones and others 0 unless stated:
  - C_IDLE: all lines 0.
  - C_WLON: wl=ALL.
  - C_INIT: wl=ALL, set=1, bl=ALL.
  - C_FEED: wl=ALL, sl≠0.
  - C_ERR: wl=ALL, sl≠0, label=1.
  - C_UPD: wl=ALL, label=1, back=1, set=0; bl and sl unconstrained.
  - C_POST: the C_ERR pattern after an update.
  - Anything else: C_BAD.
- Legal transitions:
  - IDLE→WLON; WLON→INIT; INIT→FEED; FEED→ERR; ERR→UPD; UPD→POST on back falling with label=1 and bl=0.
  - POST→IDLE on C_IDLE; also IDLE←WLON on C_IDLE (abort before init).
  - Holding the same class keeps the state.
- Other class changes go to S_FAULT; S_FAULT is sticky until rst or clear.
- Error codes: 1 = illegal transition; 2 = state left with dwell < MIN_DWELL; 3 = wl≠ALL while in INIT..POST.
  - Same-cycle priority: 3 > 1 > 2.
  - err_code latches the first error only; err sets with it.
  - Dwell violation also goes to S_FAULT.
- Dwell counter: resets on every state change and saturates at MIN_DWELL.
- ff_rows: loaded with registered sl on the S_INIT→S_FEED edge.
- upd_cnt:
  - Cleared on WLON→INIT.
  - Increments (saturating at 2^CNT_W−1) each cycle in S_UPD where registered bl≠0 and bl≠prev_bl.
  - prev_bl updates every cycle.
  - The entry cycle into S_UPD counts if bl≠0.
- seq_done: asserts for exactly one cycle on the UPD→POST edge. Never in S_FAULT.
- Simultaneous clear and error in the same cycle: clear wins.

Optional Feature:
- RRAM_MON_CELLCNT_EN defined: adds output upd_cells (16 bits).
  - Accumulates popcount(bl) on each counted update pulse, saturating at 16'hFFFF.
  - Cleared with upd_cnt, reset and clear.
- Undefined: port absent, no popcount logic.

Test Plan:
1. Nominal sequence, 10 cycles per phase: wl=FFF; set=1,bl=FFF; set=0,bl=0,sl=F00; label=1; back=1 with bl 00F→0FF→FFF→000; back=0 → phases 1,2,3,4,5,6 in order, ff_rows=F00, upd_cnt=3, one seq_done pulse, err=0; CELLCNT_EN: upd_cells=4+8+12=24.
2. Skip init: wl=FFF then sl=F00 with no set → S_FAULT, err=1, err_code=1; later legal inputs keep phase=7 until clear pulse → phase=0, err=0.
3. Drop wl[5] to 0 during S_UPD → err_code=3, phase=7, no seq_done.
4. MIN_DWELL=4, hold C_INIT 2 cycles then C_FEED → err_code=2, phase=7. Hold 4 cycles → no error.
5. 300 distinct nonzero bl changes in S_UPD → upd_cnt saturates at 255.
6. rst asserted mid-S_FEED → next cycle phase=0 and all outputs at reset values; nominal sequence afterwards passes as in test 1.

Source files
------------

// File: rtl/rram_drive_monitor.sv
// rram_drive_monitor
//
// Passive receive-side protocol checker for the RRAM unit drive interface.
// It watches the wordline/sourceline/bitline buses and the set/back/label
// strobes, follows the programming phase sequence
//   IDLE -> WL on -> init -> feed-forward -> error calc -> update -> post
// and flags illegal transitions, short dwell and wordline drop-outs. It also
// counts weight-update bitline pulses and captures the feed-forward row
// select. Nothing is driven back onto the array.
//
// All drive inputs go through one register stage before classification, so
// the phase output follows a pin change two rising edges later.
//
// Optional build macro: RRAM_MON_CELLCNT_EN adds the upd_cells output, a
// saturating sum of popcount(bl) over every counted update pulse.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   wl/sl/bl   wordline / sourceline / bitline drive, N bits each
//   set        set/initialise strobe
//   back       backprop / weight-update strobe
//   label      label / error-calc strobe
//   clear      synchronous clear of errors, counters, captures; FSM to IDLE
//   phase      current FSM state (debug view of the state register)
//   err        sticky protocol error
//   err_code   first error cause (1 illegal, 2 dwell, 3 wordline drop)
//   ff_rows    sl captured on entry to feed-forward
//   upd_cnt    update pulses in the current sequence (saturating)
//   seq_done   one-cycle pulse on update -> post
//   upd_cells  (RRAM_MON_CELLCNT_EN only) summed popcount of counted pulses
module rram_drive_monitor #(
    parameter int N         = 12,
    parameter int MIN_DWELL = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     wl,
    input  logic [N-1:0]     sl,
    input  logic [N-1:0]     bl,
    input  logic             set,
    input  logic             back,
    input  logic             label,
    input  logic             clear,
    output logic [2:0]       phase,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [N-1:0]     ff_rows,
    output logic [CNT_W-1:0] upd_cnt,
    output logic             seq_done
`ifdef RRAM_MON_CELLCNT_EN
    ,
    output logic [15:0]      upd_cells
`endif
);

    localparam int DWELL_SAT = (MIN_DWELL < 1) ? 1 : MIN_DWELL;
    localparam int DW_W      = $clog2(DWELL_SAT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLON  = 3'd1,
        S_INIT  = 3'd2,
        S_FEED  = 3'd3,
        S_ERR   = 3'd4,
        S_UPD   = 3'd5,
        S_POST  = 3'd6,
        S_FAULT = 3'd7
    } state_e;

    typedef enum logic [2:0] {
        C_IDLE = 3'd0,
        C_WLON = 3'd1,
        C_INIT = 3'd2,
        C_FEED = 3'd3,
        C_ERR  = 3'd4,
        C_UPD  = 3'd5,
        C_BAD  = 3'd6
    } class_e;

    // Registered copy of the drive pins
    logic [N-1:0] wl_q, sl_q, bl_q;
    logic         set_q, back_q, label_q;

    state_e          state_q, state_d, tgt;
    logic [DW_W-1:0] dwell_q, dwell_d;
    class_e          cls;
    logic            legal, changing, dwell_short, wl_fault;
    logic [1:0]      cause;

    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [N-1:0]     ff_rows_q, ff_rows_d;
    logic [CNT_W-1:0] upd_cnt_q, upd_cnt_d;
    logic [N-1:0]     prev_bl_q, prev_bl_d;
    logic             seq_done_q, seq_done_d;
    logic             count_pulse, cnt_restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            wl_q    <= '0;
            sl_q    <= '0;
            bl_q    <= '0;
            set_q   <= 1'b0;
            back_q  <= 1'b0;
            label_q <= 1'b0;
        end else begin
            wl_q    <= wl;
            sl_q    <= sl;
            bl_q    <= bl;
            set_q   <= set;
            back_q  <= back;
            label_q <= label;
        end
    end

    // Input classification. The post pattern is the error-calc pattern seen
    // after an update, so it shares C_ERR and the FSM tells them apart.
    always_comb begin
        cls = C_BAD;
        if (wl_q == '0 && sl_q == '0 && bl_q == '0 && !set_q && !back_q && !label_q) begin
            cls = C_IDLE;
        end else if (&wl_q) begin
            if (!set_q && !back_q && !label_q && sl_q == '0 && bl_q == '0)
                cls = C_WLON;
            else if (set_q && &bl_q && !back_q && !label_q && sl_q == '0)
                cls = C_INIT;
            else if (!set_q && !back_q && !label_q && sl_q != '0 && bl_q == '0)
                cls = C_FEED;
            else if (!set_q && !back_q && label_q && sl_q != '0 && bl_q == '0)
                cls = C_ERR;
            else if (label_q && back_q && !set_q)
                cls = C_UPD;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
        end
    end

    // Next-state logic
    always_comb begin
        tgt   = state_q;
        legal = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cls == C_IDLE) legal = 1'b1;
                else if (cls == C_WLON) begin legal = 1'b1; tgt = S_WLON; end
            end
            S_WLON: begin
                if (cls == C_WLON) legal = 1'b1;
                else if (cls == C_INIT) begin legal = 1'b1; tgt = S_INIT; end
                else if (cls == C_IDLE) begin legal = 1'b1; tgt = S_IDLE; end
            end
            S_INIT: begin
                if (cls == C_INIT) legal = 1'b1;
                else if (cls == C_FEED) begin legal = 1'b1; tgt = S_FEED; end
            end
            S_FEED: begin
                if (cls == C_FEED) legal = 1'b1;
                else if (cls == C_ERR) begin legal = 1'b1; tgt = S_ERR; end
            end
            S_ERR: begin
                if (cls == C_ERR) legal = 1'b1;
                else if (cls == C_UPD) begin legal = 1'b1; tgt = S_UPD; end
            end
            S_UPD: begin
                if (cls == C_UPD) legal = 1'b1;
                else if (cls == C_ERR) begin legal = 1'b1; tgt = S_POST; end
            end
            S_POST: begin
                if (cls == C_ERR) legal = 1'b1;
                else if (cls == C_IDLE) begin legal = 1'b1; tgt = S_IDLE; end
            end
            S_FAULT: legal = 1'b1;
            default: legal = 1'b0;
        endcase

        changing    = legal && (tgt != state_q);
        // dwell_q counts cycles already spent, so the current cycle is +1
        dwell_short = changing && (state_q != S_IDLE) && ((int'(dwell_q) + 1) < MIN_DWELL);
        // POST -> IDLE legitimately drops the wordlines, so only an illegal
        // move counts as a wordline drop-out
        wl_fault    = (state_q >= S_INIT) && (state_q <= S_POST) && !(&wl_q) && !legal;

        if (wl_fault)         cause = 2'd3;
        else if (!legal)      cause = 2'd1;
        else if (dwell_short) cause = 2'd2;
        else                  cause = 2'd0;

        state_d = (cause != 2'd0) ? S_FAULT : tgt;
        if (clear) state_d = S_IDLE;

        if (clear || state_d != state_q)
            dwell_d = '0;
        else if (dwell_q != DW_W'(DWELL_SAT))
            dwell_d = dwell_q + DW_W'(1);
        else
            dwell_d = dwell_q;
    end

    // Output / datapath next values
    always_comb begin
        seq_done_d  = (state_q == S_UPD) && (state_d == S_POST);
        count_pulse = (state_d == S_UPD) && (bl_q != '0) && (bl_q != prev_bl_q);
        cnt_restart = (state_q == S_WLON) && (state_d == S_INIT);

        err_d      = err_q;
        err_code_d = err_code_q;
        ff_rows_d  = ff_rows_q;
        upd_cnt_d  = upd_cnt_q;
        prev_bl_d  = bl_q;

        if (clear) begin
            err_d      = 1'b0;
            err_code_d = 2'd0;
            ff_rows_d  = '0;
            upd_cnt_d  = '0;
            prev_bl_d  = '0;
        end else begin
            if (!err_q && cause != 2'd0) begin
                err_d      = 1'b1;
                err_code_d = cause;
            end
            if (state_q == S_INIT && state_d == S_FEED)
                ff_rows_d = sl_q;
            if (cnt_restart)
                upd_cnt_d = '0;
            else if (count_pulse && !(&upd_cnt_q))
                upd_cnt_d = upd_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            ff_rows_q  <= '0;
            upd_cnt_q  <= '0;
            prev_bl_q  <= '0;
            seq_done_q <= 1'b0;
        end else begin
            err_q      <= err_d;
            err_code_q <= err_code_d;
            ff_rows_q  <= ff_rows_d;
            upd_cnt_q  <= upd_cnt_d;
            prev_bl_q  <= prev_bl_d;
            seq_done_q <= seq_done_d;
        end
    end

    assign phase    = state_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign ff_rows  = ff_rows_q;
    assign upd_cnt  = upd_cnt_q;
    assign seq_done = seq_done_q;

`ifdef RRAM_MON_CELLCNT_EN
    logic [15:0] cells_q, cells_d;
    logic [15:0] bl_pop;
    logic [16:0] cells_sum;

    always_comb begin
        bl_pop = '0;
        for (int i = 0; i < N; i++)
            bl_pop = bl_pop + 16'(bl_q[i]);
        cells_sum = {1'b0, cells_q} + {1'b0, bl_pop};
        cells_d   = cells_q;
        if (clear || cnt_restart)
            cells_d = '0;
        else if (count_pulse)
            cells_d = cells_sum[16] ? 16'hFFFF : cells_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (rst) cells_q <= '0;
        else     cells_q <= cells_d;
    end

    assign upd_cells = cells_q;
`endif

endmodule

// File: tb/tb_rram_drive_monitor.sv
module tb_rram_drive_monitor;
    localparam int N = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, clear;
    logic [N-1:0] wl, sl, bl;
    logic         set, back, label;

    logic [2:0]   phase, phase4;
    logic         err, err4;
    logic [1:0]   err_code, err_code4;
    logic [N-1:0] ff_rows, ff_rows4;
    logic [7:0]   upd_cnt, upd_cnt4;
    logic         seq_done, seq_done4;
`ifdef RRAM_MON_CELLCNT_EN
    logic [15:0]  upd_cells, upd_cells4;
`endif

    int checks = 0;
    int failures = 0;

    // Phase history and seq_done pulse count, written only by the monitor
    logic [2:0] exp_q[$];
    logic [2:0] seen_q[$];
    logic [2:0] last_phase;
    int         seq_pulses = 0;

    rram_drive_monitor #(.N(N), .MIN_DWELL(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .wl(wl), .sl(sl), .bl(bl),
        .set(set), .back(back), .label(label), .clear(clear),
        .phase(phase), .err(err), .err_code(err_code), .ff_rows(ff_rows),
        .upd_cnt(upd_cnt), .seq_done(seq_done)
`ifdef RRAM_MON_CELLCNT_EN
        , .upd_cells(upd_cells)
`endif
    );

    rram_drive_monitor #(.N(N), .MIN_DWELL(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .wl(wl), .sl(sl), .bl(bl),
        .set(set), .back(back), .label(label), .clear(clear),
        .phase(phase4), .err(err4), .err_code(err_code4), .ff_rows(ff_rows4),
        .upd_cnt(upd_cnt4), .seq_done(seq_done4)
`ifdef RRAM_MON_CELLCNT_EN
        , .upd_cells(upd_cells4)
`endif
    );

    always @(negedge clk) begin
        if (phase !== last_phase) begin
            seen_q.push_back(phase);
            last_phase = phase;
        end
        if (seq_done === 1'b1) seq_pulses++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] w, input logic [N-1:0] s, input logic [N-1:0] b,
                         input logic st, input logic bk, input logic lb);
        wl = w; sl = s; bl = b; set = st; back = bk; label = lb;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear = 1'b0;
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(2);
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        clear = 1'b0;
        drive(12'hFFF, 12'h0F0, 12'hFFF, 1'b1, 1'b1, 1'b1);
        step(2);
        checks++; if (phase !== 3'd0) begin failures++; $display("FAIL reset_phase got %0d expected 0", phase); end
        checks++; if (err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL reset_err got %b/%0d expected 0/0", err, err_code); end
        checks++; if (ff_rows !== '0 || upd_cnt !== 8'd0 || seq_done !== 1'b0) begin failures++; $display("FAIL reset_data got ff=%h cnt=%0d sd=%b expected 0", ff_rows, upd_cnt, seq_done); end
        checks++; if (phase4 !== 3'd0 || err4 !== 1'b0) begin failures++; $display("FAIL reset_dut4 got %0d/%b expected 0/0", phase4, err4); end
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(3);
        checks++; if (phase !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL reset_release got %0d/%b expected 0/0", phase, err); end
    endtask

    task automatic test_nominal(input string tag);
        int base;
        int sbase;
        do_reset();
        base = seen_q.size();
        sbase = seq_pulses;
        drive(12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); step(10);
        checks++; if (phase !== 3'd1) begin failures++; $display("FAIL %s wlon got %0d expected 1", tag, phase); end
        drive(12'hFFF, 12'h000, 12'hFFF, 1'b1, 1'b0, 1'b0); step(10);
        checks++; if (phase !== 3'd2) begin failures++; $display("FAIL %s init got %0d expected 2", tag, phase); end
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b0); step(10);
        checks++; if (phase !== 3'd3) begin failures++; $display("FAIL %s feed got %0d expected 3", tag, phase); end
        checks++; if (ff_rows !== 12'hF00) begin failures++; $display("FAIL %s ff_rows got %h expected f00", tag, ff_rows); end
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b1); step(10);
        checks++; if (phase !== 3'd4) begin failures++; $display("FAIL %s errcalc got %0d expected 4", tag, phase); end
        drive(12'hFFF, 12'hF00, 12'h00F, 1'b0, 1'b1, 1'b1); step(10);
        checks++; if (phase !== 3'd5 || upd_cnt !== 8'd1) begin failures++; $display("FAIL %s upd_entry got %0d/%0d expected 5/1", tag, phase, upd_cnt); end
        drive(12'hFFF, 12'hF00, 12'h0FF, 1'b0, 1'b1, 1'b1); step(10);
        drive(12'hFFF, 12'hF00, 12'hFFF, 1'b0, 1'b1, 1'b1); step(10);
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b1, 1'b1); step(10);
        checks++; if (upd_cnt !== 8'd3) begin failures++; $display("FAIL %s upd_cnt got %0d expected 3", tag, upd_cnt); end
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b1); step(10);
        checks++; if (phase !== 3'd6) begin failures++; $display("FAIL %s post got %0d expected 6", tag, phase); end
        checks++; if (seq_pulses - sbase !== 1) begin failures++; $display("FAIL %s seq_done_pulses got %0d expected 1", tag, seq_pulses - sbase); end
        checks++; if (err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL %s err got %b/%0d expected 0/0", tag, err, err_code); end
`ifdef RRAM_MON_CELLCNT_EN
        checks++; if (upd_cells !== 16'd24) begin failures++; $display("FAIL %s upd_cells got %0d expected 24", tag, upd_cells); end
`endif
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0); step(10);
        checks++; if (phase !== 3'd0) begin failures++; $display("FAIL %s back_to_idle got %0d expected 0", tag, phase); end
        exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
        checks++;
        if (seen_q.size() - base !== exp_q.size()) begin
            failures++;
            $display("FAIL %s phase_log_len got %0d expected %0d", tag, seen_q.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (seen_q[base + i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL %s phase_log[%0d] got %0d expected %0d", tag, i, seen_q[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_skip_init;
        do_reset();
        drive(12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); step(10);
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b0); step(5);
        checks++; if (phase !== 3'd7 || err !== 1'b1 || err_code !== 2'd1) begin failures++; $display("FAIL skip_init got %0d/%b/%0d expected 7/1/1", phase, err, err_code); end
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0); step(5);
        drive(12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); step(5);
        checks++; if (phase !== 3'd7 || err_code !== 2'd1) begin failures++; $display("FAIL fault_sticky got %0d/%0d expected 7/1", phase, err_code); end
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0); step(3);
        clear = 1'b1; step(1); clear = 1'b0; step(3);
        checks++; if (phase !== 3'd0 || err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL clear got %0d/%b/%0d expected 0/0/0", phase, err, err_code); end
    endtask

    task automatic test_wl_drop;
        int sbase;
        do_reset();
        drive(12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); step(10);
        drive(12'hFFF, 12'h000, 12'hFFF, 1'b1, 1'b0, 1'b0); step(10);
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b0); step(10);
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b1); step(10);
        drive(12'hFFF, 12'hF00, 12'h00F, 1'b0, 1'b1, 1'b1); step(10);
        sbase = seq_pulses;
        drive(12'hFDF, 12'hF00, 12'h00F, 1'b0, 1'b1, 1'b1); step(5);
        checks++; if (phase !== 3'd7 || err !== 1'b1 || err_code !== 2'd3) begin failures++; $display("FAIL wl_drop got %0d/%b/%0d expected 7/1/3", phase, err, err_code); end
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b1); step(5);
        checks++; if (phase !== 3'd7 || seq_pulses - sbase !== 0) begin failures++; $display("FAIL wl_drop_no_done got %0d/%0d expected 7/0", phase, seq_pulses - sbase); end
    endtask

    task automatic test_min_dwell;
        do_reset();
        drive(12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); step(4);
        drive(12'hFFF, 12'h000, 12'hFFF, 1'b1, 1'b0, 1'b0); step(2);
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b0); step(5);
        checks++; if (phase4 !== 3'd7 || err4 !== 1'b1 || err_code4 !== 2'd2) begin failures++; $display("FAIL dwell_short got %0d/%b/%0d expected 7/1/2", phase4, err4, err_code4); end
        checks++; if (phase !== 3'd3 || err !== 1'b0) begin failures++; $display("FAIL dwell_one got %0d/%b expected 3/0", phase, err); end
        do_reset();
        drive(12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); step(4);
        drive(12'hFFF, 12'h000, 12'hFFF, 1'b1, 1'b0, 1'b0); step(4);
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b0); step(5);
        checks++; if (phase4 !== 3'd3 || err4 !== 1'b0 || err_code4 !== 2'd0) begin failures++; $display("FAIL dwell_ok got %0d/%b/%0d expected 3/0/0", phase4, err4, err_code4); end
        checks++; if (ff_rows4 !== 12'hF00) begin failures++; $display("FAIL dwell_ok_rows got %h expected f00", ff_rows4); end
    endtask

    task automatic test_saturation;
        do_reset();
        drive(12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); step(10);
        drive(12'hFFF, 12'h000, 12'hFFF, 1'b1, 1'b0, 1'b0); step(10);
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b0); step(10);
        drive(12'hFFF, 12'hF00, 12'h000, 1'b0, 1'b0, 1'b1); step(10);
        for (int i = 0; i < 300; i++) begin
            drive(12'hFFF, 12'hF00, (i % 2 == 0) ? 12'h001 : 12'h002, 1'b0, 1'b1, 1'b1);
            step(1);
        end
        step(3);
        checks++; if (upd_cnt !== 8'd255) begin failures++; $display("FAIL upd_sat got %0d expected 255", upd_cnt); end
        checks++; if (phase !== 3'd5 || err !== 1'b0) begin failures++; $display("FAIL upd_sat_state got %0d/%b expected 5/0", phase, err); end
`ifdef RRAM_MON_CELLCNT_EN
        checks++; if (upd_cells !== 16'd300) begin failures++; $display("FAIL upd_sat_cells got %0d expected 300", upd_cells); end
`endif
    endtask

    task automatic test_reset_mid;
        do_reset();
        drive(12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0, 1'b0); step(10);
        drive(12'hFFF, 12'h000, 12'hFFF, 1'b1, 1'b0, 1'b0); step(10);
        drive(12'hFFF, 12'h0A5, 12'h000, 1'b0, 1'b0, 1'b0); step(5);
        checks++; if (phase !== 3'd3 || ff_rows !== 12'h0A5) begin failures++; $display("FAIL mid_pre got %0d/%h expected 3/0a5", phase, ff_rows); end
        rst = 1'b1;
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        step(1);
        checks++; if (phase !== 3'd0 || err !== 1'b0 || err_code !== 2'd0) begin failures++; $display("FAIL mid_rst_state got %0d/%b/%0d expected 0/0/0", phase, err, err_code); end
        checks++; if (ff_rows !== '0 || upd_cnt !== 8'd0 || seq_done !== 1'b0) begin failures++; $display("FAIL mid_rst_data got %h/%0d/%b expected 0", ff_rows, upd_cnt, seq_done); end
        rst = 1'b0;
        step(2);
        test_nominal("after_rst");
    endtask

    initial begin
        rst = 1'b1;
        clear = 1'b0;
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_nominal("nominal");
        test_skip_init();
        test_wl_drop();
        test_min_dwell();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
